// File: rtl/str_up_sample_pkg.sv
// Shared types and helpers for the stream interpolator and its frame checker.
//   state_t        : interpolator FSM states (EMPTY waits for a sample, EMIT drives L outputs)
//   DefDw/DefLLog2 : default sample width and log2 interpolation factor
//   DefFrame       : default expected input samples per frame
//   L              : interpolation factor for the default configuration
//   interp_width() : width of the d*k product, DW+1 bits of difference plus L_LOG2+1 bits of k
//   l_factor()     : interpolation factor for a given log2 factor
package str_up_sample_pkg;

  typedef enum logic [0:0] {
    EMPTY,
    EMIT
  } state_t;

  localparam int unsigned DefDw    = 24;
  localparam int unsigned DefLLog2 = 2;
  localparam int unsigned DefFrame = 4000;
  localparam int unsigned L        = 1 << DefLLog2;

  function automatic int unsigned interp_width(int unsigned dw, int unsigned l_log2);
    return dw + 1 + l_log2 + 1;
  endfunction

  function automatic int unsigned l_factor(int unsigned l_log2);
    return 1 << l_log2;
  endfunction

endpackage

// File: rtl/str_frame_check.sv
// Frame-length checker for a framed input stream.
// Counts accepted samples and compares the tlast position against FRAME.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_accept     : a sample is accepted this cycle
//   i_last       : tlast of the accepted sample
//   o_frame_err  : one-cycle pulse the cycle after a frame-length violation
// A missing tlast at the expected boundary resyncs the count to that boundary.
module str_frame_check #(
  parameter int unsigned FRAME = 4000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_accept,
  input  logic i_last,
  output logic o_frame_err
);

  localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_at_end;

  assign w_at_end    = (r_cnt == CW'(FRAME - 1));
  assign o_frame_err = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_accept) begin
        if (i_last) begin
          r_err <= !w_at_end;
          r_cnt <= '0;
        end else if (w_at_end) begin
          r_err <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/str_up_sample.sv
// AXI-stream linear interpolator: emits L = 2**L_LOG2 samples per input sample,
// ramping from the previous input to the current one, with frame reconstruction.
//   clk, rst       : clock, asynchronous active-high reset
//   s_axis_*       : low-rate signed input stream (tdata/tvalid/tready/tlast)
//   m_axis_*       : high-rate signed output stream (tdata/tvalid/tready/tlast)
//   frame_err      : one-cycle pulse when the input frame length differs from FRAME
// Output k (1..L) of a sample is x_prev + floor((x_cur - x_prev) * k / L).
module str_up_sample
  import str_up_sample_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned L_LOG2 = DefLLog2,
  parameter int unsigned FRAME  = DefFrame
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          frame_err
);

  localparam int unsigned LFac = l_factor(L_LOG2);
  localparam int unsigned KW   = L_LOG2 + 1;
  localparam int unsigned PW   = interp_width(DW, L_LOG2);

  state_t               r_state;
  logic signed [DW-1:0] r_x_prev;
  logic signed [DW-1:0] r_x_cur;
  logic [KW-1:0]        r_k;
  logic                 r_last;
  logic [DW-1:0]        r_tdata;
  logic                 r_tvalid;
  logic                 r_tlast;

  logic                 w_m_hs;
  logic                 w_final;
  logic                 w_accept;

  logic signed [DW-1:0] w_ip_prev;
  logic signed [DW-1:0] w_ip_cur;
  logic [KW-1:0]        w_ip_k;
  logic signed [DW:0]   w_d;
  logic signed [PW-1:0] w_d_ext;
  logic signed [PW-1:0] w_k_ext;
  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_shift;
  logic [PW-1:0]        w_sum;
  logic [DW-1:0]        w_y;
  logic [PW-DW-1:0]     w_unused_sum;

  assign w_m_hs   = r_tvalid && m_axis_tready;
  assign w_final  = (r_k == KW'(LFac));
  // Ready while idle, or on the last-phase handshake so the next sample loads without a bubble.
  assign s_axis_tready = !rst && ((r_state == EMPTY) || (w_m_hs && w_final));
  assign w_accept = s_axis_tvalid && s_axis_tready;

  // The output register is loaded with the value for the phase that comes next, so the
  // interpolator sees either the incoming sample pair at k=1 or the current pair at k+1.
  assign w_ip_prev = w_accept ? r_x_cur : r_x_prev;
  assign w_ip_cur  = w_accept ? $signed(s_axis_tdata) : r_x_cur;
  assign w_ip_k    = w_accept ? KW'(1) : r_k + KW'(1);

  assign w_d     = {w_ip_cur[DW-1], w_ip_cur} - {w_ip_prev[DW-1], w_ip_prev};
  assign w_d_ext = {{(PW-DW-1){w_d[DW]}}, w_d};
  assign w_k_ext = {{(PW-KW){1'b0}}, w_ip_k};
  assign w_p     = w_d_ext * w_k_ext;
  // Kept in its own signed net so the shift stays arithmetic (floor rounding).
  assign w_shift = w_p >>> L_LOG2;
  assign w_sum   = {{(PW-DW){w_ip_prev[DW-1]}}, w_ip_prev} + w_shift;
  // The result lies between x_prev and x_cur, so dropping the upper bits is exact.
  assign w_y          = w_sum[DW-1:0];
  assign w_unused_sum = w_sum[PW-1:DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_x_prev <= '0;
      r_x_cur  <= '0;
      r_k      <= '0;
      r_last   <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_x_prev <= r_x_cur;
      r_x_cur  <= $signed(s_axis_tdata);
      r_last   <= s_axis_tlast;
      r_k      <= KW'(1);
      r_state  <= EMIT;
      r_tdata  <= w_y;
      r_tvalid <= 1'b1;
      r_tlast  <= s_axis_tlast && (LFac == 1);
    end else if (w_m_hs) begin
      if (w_final) begin
        // Output data holds its last value while idle.
        r_state  <= EMPTY;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end else begin
        r_k     <= r_k + KW'(1);
        r_tdata <= w_y;
        r_tlast <= r_last && ((r_k + KW'(1)) == KW'(LFac));
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

  str_frame_check #(
    .FRAME(FRAME)
  ) u_frame_check (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_accept   (w_accept),
    .i_last     (s_axis_tlast),
    .o_frame_err(frame_err)
  );

endmodule
